// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: funct codes, the
// operation-class encoding carried down the pipe, the per-stage control
// payload and the helpers that spread mux levels across register slices.
// Honours PIPE_BARREL_SHIFTER_ROR_EN (rotate support compiled in).
package shifter_pkg;

  localparam logic [5:0] OP_SLL = 6'b000000;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_ROR = 6'b000110;

  // Direction class seen by every mux level; decoded once at the input.
  typedef enum logic [1:0] {
    CLS_LEFT  = 2'd0,
    CLS_RIGHT = 2'd1,
    CLS_ROT   = 2'd2
  } shift_cls_e;

  // Control part of the stage payload {data, shamt_lo, op, fill, err}.
  // data and shamt_lo depend on the instance WIDTH, so the top wraps this
  // struct together with them in its own payload typedef.
  typedef struct packed {
    shift_cls_e op;
    logic       fill;
    logic       err;
  } stage_ctrl_t;

  // True for the funct codes this build can execute.
  function automatic logic is_supported_op(input logic [5:0] op);
    logic ok;
    ok = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
`ifdef PIPE_BARREL_SHIFTER_ROR_EN
    ok = ok || (op == OP_ROR);
`endif
    return ok;
  endfunction

  // Number of mux levels handled before register slice s; surplus levels
  // are handed to the earliest slices.
  function automatic int slice_first(input int s, input int levels, input int stages);
    int base;
    int extra;
    base  = levels / stages;
    extra = levels % stages;
    return s * base + ((s < extra) ? s : extra);
  endfunction

  // Number of mux levels placed in front of register slice s.
  function automatic int slice_count(input int s, input int levels, input int stages);
    int base;
    int extra;
    base  = levels / stages;
    extra = levels % stages;
    return base + ((s < extra) ? 1 : 0);
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational mux level of the barrel shifter: either passes the data
// through or moves it by DIST bit positions in the direction of the op class.
// Rotate wiring exists only with PIPE_BARREL_SHIFTER_ROR_EN defined.
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             sel,
  input  shift_cls_e       cls,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] moved;

  // Build the moved word for this level, then select it when the amount bit is set.
  always_comb begin
    moved = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
    case (cls)
      CLS_LEFT:  moved = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
      CLS_RIGHT: moved = {{DIST{fill}}, data[WIDTH-1:DIST]};
`ifdef PIPE_BARREL_SHIFTER_ROR_EN
      CLS_ROT:   moved = {data[DIST-1:0], data[WIDTH-1:DIST]};
`endif
      default:   moved = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
    endcase
    result = sel ? moved : data;
  end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined SLL/SRL/SRA (and optional ROR) barrel shifter for the EX stage.
// $clog2(WIDTH) mux levels are split across STAGES register slices, with
// the extra levels placed in the earliest slices. Out-of-range amounts and
// unsupported ops are resolved at the input so the levels only ever see a
// plain shift by shamt[L-1:0].
// Build option: PIPE_BARREL_SHIFTER_ROR_EN enables the rotate mode (000110).
module pipe_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam int L = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [L-1:0]     shamt_lo;
    stage_ctrl_t      ctrl;
  } payload_t;

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high; valid never depends on ready. The whole pipe moves as one when
  // advance = !out_valid | out_ready, so an unconsumed result freezes every
  // slice (bubbles included) and in_ready mirrors advance. flush clears all
  // valid bits on the next edge and drops a same-cycle input.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  payload_t         dec;
  logic             big_amount;
  payload_t         stage_d [STAGES];
  payload_t         stage_q [STAGES];
  logic [STAGES-1:0] stage_v;
  logic [STAGES:0]   v_chain;

  assign big_amount = |in_shamt[WIDTH-1:L];
  assign v_chain    = {stage_v, in_valid};

  // Input decode: op class, SRA fill bit, out-of-range amounts and errors.
  always_comb begin
    dec          = '0;
    dec.ctrl.op  = CLS_LEFT;
    if (!is_supported_op(in_op)) begin
      dec.ctrl.err = 1'b1;
    end else begin
      case (in_op)
        OP_SRL: dec.ctrl.op = CLS_RIGHT;
        OP_SRA: begin
          dec.ctrl.op   = CLS_RIGHT;
          dec.ctrl.fill = in_data[WIDTH-1];
        end
`ifdef PIPE_BARREL_SHIFTER_ROR_EN
        OP_ROR: dec.ctrl.op = CLS_ROT;
`endif
        default: dec.ctrl.op = CLS_LEFT;
      endcase
      // Shifts by WIDTH or more collapse to the fill pattern; a rotate
      // simply uses the amount modulo WIDTH, i.e. its low L bits.
      if (big_amount && (dec.ctrl.op != CLS_ROT)) begin
        dec.data     = {WIDTH{dec.ctrl.fill}};
        dec.shamt_lo = '0;
      end else begin
        dec.data     = in_data;
        dec.shamt_lo = in_shamt[L-1:0];
      end
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_slice
    localparam int FIRST = slice_first(s, L, STAGES);
    localparam int CNT   = slice_count(s, L, STAGES);

    payload_t         src;
    logic [WIDTH-1:0] chain [CNT+1];

    if (s == 0) begin : g_head
      assign src = dec;
    end else begin : g_tail
      assign src = stage_q[s-1];
    end

    assign chain[0] = src.data;

    // Level LVL moves by 2^(L-1-LVL) and is steered by amount bit L-1-LVL.
    for (genvar j = 0; j < CNT; j++) begin : g_lvl
      localparam int LVL = FIRST + j;
      shift_level #(
        .WIDTH (WIDTH),
        .DIST  (1 << (L - 1 - LVL))
      ) u_level (
        .data   (chain[j]),
        .sel    (src.shamt_lo[L-1-LVL]),
        .cls    (src.ctrl.op),
        .fill   (src.ctrl.fill),
        .result (chain[j+1])
      );
    end

    assign stage_d[s].data     = chain[CNT];
    assign stage_d[s].shamt_lo = src.shamt_lo;
    assign stage_d[s].ctrl     = src.ctrl;
  end

  // Register slices: shift together on advance, hold otherwise, flush kills valids.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      if (advance) begin
        stage_v <= v_chain[STAGES-1:0];
        for (int i = 0; i < STAGES; i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
      if (flush) begin
        stage_v <= '0;
      end
    end
  end

  assign out_valid = stage_v[STAGES-1];
  assign out_data  = stage_q[STAGES-1].data;
  assign out_err   = stage_q[STAGES-1].ctrl.err;

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Bench for pipe_barrel_shifter (WIDTH=32, STAGES=3). Expected results come
// from a plain-arithmetic reference of the shift rules; a queue scoreboard
// tracks accepted operations, and latency is checked for every result that
// never saw an output stall. Follows PIPE_BARREL_SHIFTER_ROR_EN like the RTL.
module tb_pipe_barrel_shifter;
  import shifter_pkg::*;

  localparam int WIDTH  = 32;
  localparam int STAGES = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_op;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] in_shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  pipe_barrel_shifter #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int               n_assert   = 0;
  int               n_fail     = 0;
  int               cyc        = 0;
  int               last_stall = -1;
  logic [WIDTH:0]   exp_q[$];
  int               acc_q[$];
  logic             prev_stall = 1'b0;
  logic [WIDTH:0]   prev_out   = '0;

  // Reference: {err, result} straight from the shift rules.
  function automatic logic [WIDTH:0] ref_model(input logic [5:0] op,
                                               input logic [WIDTH-1:0] d,
                                               input logic [WIDTH-1:0] sh);
    logic [WIDTH-1:0] r;
    int               s;
    r = '0;
    s = 0;
    case (op)
      OP_SLL: r = (sh >= WIDTH) ? '0 : (d << sh);
      OP_SRL: r = (sh >= WIDTH) ? '0 : (d >> sh);
      OP_SRA: r = (sh >= WIDTH) ? {WIDTH{d[WIDTH-1]}} : WIDTH'($signed(d) >>> sh);
`ifdef PIPE_BARREL_SHIFTER_ROR_EN
      OP_ROR: begin
        s = int'(sh % WIDTH);
        r = (d >> s) | (d << (WIDTH - s));
      end
`endif
      default: return {1'b1, {WIDTH{1'b0}}};
    endcase
    return {1'b0, r};
  endfunction

  task automatic check(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_assert++;
    assert (got == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Called at a falling edge: drives inputs, samples outputs mid-cycle,
  // updates the scoreboard at the rising edge, returns at the next fall.
  task automatic step(input logic v, input logic [5:0] op, input logic [WIDTH-1:0] d,
                      input logic [WIDTH-1:0] sh, input logic ordy, input logic fl);
    logic acc;
    logic [WIDTH:0] exp;
    int   acc_cyc;
    in_valid  = v;
    in_op     = op;
    in_data   = d;
    in_shamt  = sh;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (prev_stall) begin
      check_bit("stall_valid", out_valid, 1'b1);
      check("stall_hold", {out_err, out_data}, prev_out);
    end
    if (out_valid && out_ready) begin
      check_bit("out_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        exp     = exp_q.pop_front();
        acc_cyc = acc_q.pop_front();
        check("result", {out_err, out_data}, exp);
        if (last_stall < acc_cyc) check_int("latency", cyc - acc_cyc, STAGES);
      end
    end
    acc        = v && in_ready && !fl && !rst;
    prev_stall = out_valid && !out_ready && !fl && !rst;
    prev_out   = {out_err, out_data};
    if (out_valid && !out_ready) last_stall = cyc;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      acc_q.delete();
    end else if (acc) begin
      exp_q.push_back(ref_model(op, d, sh));
      acc_q.push_back(cyc);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, OP_SLL, '0, '0, ordy, 1'b0);
  endtask

  // Empty the pipe with out_ready high; an overrun counts as a failure.
  task automatic drain();
    int budget;
    budget = 4 * STAGES + 20;
    while (exp_q.size() > 0 && budget > 0) begin
      idle(1'b1);
      budget--;
    end
    check_int("drain_empty", exp_q.size(), 0);
  endtask

  task automatic single(input logic [5:0] op, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] sh);
    step(1'b1, op, d, sh, 1'b1, 1'b0);
    drain();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random sequence ----------------
  initial begin
    logic [5:0]       op;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] sh;
    int               r;

    // reset
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_data = '0; in_shamt = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", {out_err, out_data}, '0);
    check_bit("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    idle(1'b1);

    // basic shifts, range boundaries, zero amount
    single(OP_SRL, 32'h8000_0000, 32'd31);
    single(OP_SLL, 32'h0000_0001, 32'd4);
    single(OP_SRA, 32'hF000_0000, 32'd4);
    single(OP_SRA, 32'hF000_0000, 32'd40);
    single(OP_SRL, 32'hFFFF_FFFF, 32'd32);
    single(OP_SLL, 32'h1234_5678, 32'h0001_0003);
    single(OP_SRA, 32'h7000_0000, 32'hFFFF_FFFF);
    single(OP_SRL, 32'hDEAD_BEEF, 32'd0);
    single(OP_SRA, 32'h8000_0001, 32'd0);
    single(OP_ROR, 32'h0000_0001, 32'd1);
    single(OP_ROR, 32'h0000_0001, 32'd33);
    single(OP_ROR, 32'hCAFE_F00D, 32'd0);
    single(6'b111111, 32'hFFFF_FFFF, 32'd3);
    single(6'b000001, 32'h0000_00FF, 32'd40);

    // back-to-back stream with a three-cycle output stall
    for (int i = 0; i < 10; i++) begin
      step(1'b1, (i % 2 == 0) ? OP_SRA : OP_SLL, $urandom, WIDTH'($urandom_range(0, 40)),
           !(i >= 4 && i <= 6), 1'b0);
    end
    drain();

    // fill and stall the pipe, then flush it
    for (int i = 0; i < STAGES + 1; i++) begin
      step(1'b1, OP_SRL, $urandom, WIDTH'(i + 1), 1'b0, 1'b0);
    end
    check_bit("full_stalled_ready", in_ready, 1'b0);
    step(1'b1, OP_SLL, 32'h5555_5555, 32'd1, 1'b0, 1'b1);
    check_bit("flush_out_valid", out_valid, 1'b0);
    repeat (STAGES + 2) idle(1'b1);
    single(OP_SLL, 32'h0000_0003, 32'd5);

    // asynchronous reset in the middle of a stream
    for (int i = 0; i < STAGES + 2; i++) begin
      step(1'b1, OP_SLL, $urandom, WIDTH'(i), 1'b1, 1'b0);
    end
    check_bit("pre_rst_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_bit("async_rst_valid", out_valid, 1'b0);
    check("async_rst_data", {out_err, out_data}, '0);
    exp_q.delete();
    acc_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    idle(1'b1);
    rst = 1'b0;
    idle(1'b1);
    single(OP_SLL, 32'h0000_00A5, 32'd8);

    // randomized traffic with backpressure and occasional flushes
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      op = OP_SLL;
      else if (r <= 4) op = OP_SRL;
      else if (r <= 6) op = OP_SRA;
      else if (r <= 8) op = OP_ROR;
      else             op = 6'($urandom_range(0, 63));
      d  = $urandom;
      r  = $urandom_range(0, 7);
      if (r == 0)      sh = $urandom;
      else if (r == 1) sh = WIDTH;
      else             sh = WIDTH'($urandom_range(0, WIDTH - 1));
      step($urandom_range(0, 4) != 0, op, d, sh, $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
